// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes over STAGES
// downstream stages and produces the D-stage stall and operand forward selects.
// Define HAZARD_MD_EN to add the HI/LO (mult/div unit) busy interlock ports.
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int TNEW_W = 2,
    parameter int REG_W  = 5,
    localparam int SEL_W = $clog2(STAGES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    d_valid,
    input  logic [REG_W-1:0]        d_rs,
    input  logic [REG_W-1:0]        d_rt,
    input  logic [TNEW_W-1:0]       d_tuse_rs,
    input  logic [TNEW_W-1:0]       d_tuse_rt,
    input  logic [REG_W-1:0]        d_a3,
    input  logic                    d_regwrite,
    input  logic [TNEW_W-1:0]       d_tnew,
`ifdef HAZARD_MD_EN
    input  logic                    d_md_op,
    input  logic                    md_busy,
    input  logic                    md_start,
`endif
    output logic                    stall,
    output logic [SEL_W-1:0]        fwd_rs_sel,
    output logic [SEL_W-1:0]        fwd_rt_sel,
    output logic [STAGES*REG_W-1:0] stage_a3
);

    // Index i holds the entry for stage i+1 (i = 0 is the E stage).
    logic [REG_W-1:0]  a3_q   [STAGES];
    logic              we_q   [STAGES];
    logic [TNEW_W-1:0] tnew_q [STAGES];
    logic [REG_W-1:0]  a3_d   [STAGES];
    logic              we_d   [STAGES];
    logic [TNEW_W-1:0] tnew_d [STAGES];

    logic              rsHit;
    logic              rtHit;
    logic [TNEW_W-1:0] rsTnew;
    logic [TNEW_W-1:0] rtTnew;
    logic [SEL_W-1:0]  rsIdx;
    logic [SEL_W-1:0]  rtIdx;
    logic              regStall;
    logic              mdStall;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        rsHit  = 1'b0;
        rtHit  = 1'b0;
        rsTnew = '0;
        rtTnew = '0;
        rsIdx  = '0;
        rtIdx  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (we_q[i] && (a3_q[i] != '0) && (a3_q[i] == d_rs)) begin
                rsHit  = 1'b1;
                rsTnew = tnew_q[i];
                rsIdx  = SEL_W'(i + 1);
            end
            if (we_q[i] && (a3_q[i] != '0) && (a3_q[i] == d_rt)) begin
                rtHit  = 1'b1;
                rtTnew = tnew_q[i];
                rtIdx  = SEL_W'(i + 1);
            end
        end
    end

    always_comb begin
        regStall = d_valid && ((rsHit && (rsTnew > d_tuse_rs)) ||
                               (rtHit && (rtTnew > d_tuse_rt)));
`ifdef HAZARD_MD_EN
        mdStall  = d_valid && d_md_op && (md_busy || md_start);
`else
        mdStall  = 1'b0;
`endif
        stall      = regStall || mdStall;
        fwd_rs_sel = (rsHit && (rsTnew == '0)) ? rsIdx : '0;
        fwd_rt_sel = (rtHit && (rtTnew == '0)) ? rtIdx : '0;
    end

    // A stalled or empty D stage injects a bubble; older entries age by one.
    always_comb begin
        if (d_valid && !stall) begin
            a3_d[0]   = d_a3;
            we_d[0]   = d_regwrite;
            tnew_d[0] = d_tnew;
        end else begin
            a3_d[0]   = '0;
            we_d[0]   = 1'b0;
            tnew_d[0] = '0;
        end
        for (int i = 1; i < STAGES; i++) begin
            a3_d[i]   = a3_q[i-1];
            we_d[i]   = we_q[i-1];
            tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TNEW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                a3_q[i]   <= '0;
                we_q[i]   <= 1'b0;
                tnew_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                a3_q[i]   <= a3_d[i];
                we_q[i]   <= we_d[i];
                tnew_q[i] <= tnew_d[i];
            end
        end
    end

    always_comb begin
        stage_a3 = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_a3[i*REG_W +: REG_W] = we_q[i] ? a3_q[i] : '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard (default 3 stages, 2-bit Tnew, 5-bit regs).
// The mult/div interlock scenario is exercised when built with HAZARD_MD_EN.
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic [4:0]  d_a3;
    logic        d_regwrite;
    logic [1:0]  d_tnew;
`ifdef HAZARD_MD_EN
    logic        d_md_op;
    logic        md_busy;
    logic        md_start;
`endif
    logic        stall;
    logic [1:0]  fwd_rs_sel;
    logic [1:0]  fwd_rt_sel;
    logic [14:0] stage_a3;

    int testsRun;
    int testsFailed;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_a3       (d_a3),
        .d_regwrite (d_regwrite),
        .d_tnew     (d_tnew),
`ifdef HAZARD_MD_EN
        .d_md_op    (d_md_op),
        .md_busy    (md_busy),
        .md_start   (md_start),
`endif
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .stage_a3   (stage_a3)
    );

    // Rising edges at 5, 15, 25...; inputs change on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic driveD(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [1:0] tuRs, input logic [1:0] tuRt,
                          input logic [4:0] a3, input logic rw, input logic [1:0] tn);
        d_valid    = v;
        d_rs       = rs;
        d_rt       = rt;
        d_tuse_rs  = tuRs;
        d_tuse_rt  = tuRt;
        d_a3       = a3;
        d_regwrite = rw;
        d_tnew     = tn;
    endtask

    task automatic flush();
        repeat (4) begin
            @(negedge clk);
            driveD(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        driveD(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
        #2;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || stage_a3 !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_init: stall=%0b rs=%0d rt=%0d a3=%h, need 0/0/0/0",
                     stall, fwd_rs_sel, fwd_rt_sel, stage_a3);
        end
        @(negedge clk);
        reset = 1'b1;
        // Three writers to $7 with Tnew 2 fill every stage.
        repeat (3) begin
            driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 1'b1, 2'd2);
            @(negedge clk);
        end
        driveD(1'b1, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b1 || stage_a3 !== 15'd7399) begin
            testsFailed++;
            $display("[TB] FAIL reset_filled: stall=%0b a3=%0d, need 1/7399", stall, stage_a3);
        end
        #1 reset = 1'b0;
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0 || stage_a3 !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async: stall=%0b rs=%0d rt=%0d a3=%0d, need 0/0/0/0",
                     stall, fwd_rs_sel, fwd_rt_sel, stage_a3);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || stage_a3 !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_after: stall=%0b rs=%0d a3=%0d, need 0/0/0",
                     stall, fwd_rs_sel, stage_a3);
        end
    endtask

    task automatic test_load_use();
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2);
        #1;
        testsRun++;
        if (stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lw_issue: stall=%0b, need 0", stall);
        end
        @(negedge clk);
        driveD(1'b1, 5'd1, 5'd0, 2'd1, 2'd3, 5'd2, 1'b1, 2'd1);
        #1;
        testsRun++;
        if (stall !== 1'b1 || stage_a3 !== 15'd1) begin
            testsFailed++;
            $display("[TB] FAIL load_use_stall: stall=%0b a3=%0d, need 1/1", stall, stage_a3);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || stage_a3 !== 15'd32) begin
            testsFailed++;
            $display("[TB] FAIL load_use_release: stall=%0b rs=%0d a3=%0d, need 0/0/32",
                     stall, fwd_rs_sel, stage_a3);
        end
    endtask

    task automatic test_branch_load();
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd1, 1'b1, 2'd2);
        @(negedge clk);
        driveD(1'b1, 5'd1, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        for (int c = 0; c < 2; c++) begin
            #1;
            testsRun++;
            if (stall !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL beq_lw_stall%0d: stall=%0b, need 1", c, stall);
            end
            @(negedge clk);
        end
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd3 || fwd_rt_sel !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL beq_lw_fwd: stall=%0b rs=%0d rt=%0d, need 0/3/0",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
    endtask

    task automatic test_alu_branch();
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 1'b1, 2'd1);
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd3, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL alu_beq_stall: stall=%0b, need 1", stall);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rt_sel !== 2'd2 || fwd_rs_sel !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL alu_beq_fwd: stall=%0b rt=%0d rs=%0d, need 0/2/0",
                     stall, fwd_rt_sel, fwd_rs_sel);
        end
    endtask

    task automatic test_fwd_priority();
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd0);
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 1'b1, 2'd0);
        @(negedge clk);
        driveD(1'b1, 5'd5, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd1 || fwd_rt_sel !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL fwd_youngest: stall=%0b rs=%0d rt=%0d, need 0/1/0",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        // Older $6 still has Tnew 2 in stage 2; the ready stage-1 copy decides.
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 1'b1, 2'd3);
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd6, 1'b1, 2'd0);
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd6, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rt_sel !== 2'd1) begin
            testsFailed++;
            $display("[TB] FAIL older_ignored: stall=%0b rt=%0d, need 0/1", stall, fwd_rt_sel);
        end
    endtask

    task automatic test_no_hazard();
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd3);
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b0 || fwd_rs_sel !== 2'd0 || fwd_rt_sel !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL zero_reg: stall=%0b rs=%0d rt=%0d, need 0/0/0",
                     stall, fwd_rs_sel, fwd_rt_sel);
        end
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b0, 2'd2);
        @(negedge clk);
        driveD(1'b1, 5'd8, 5'd8, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        testsRun++;
        if (stall !== 1'b0 || stage_a3 !== 15'd0) begin
            testsFailed++;
            $display("[TB] FAIL no_regwrite: stall=%0b a3=%0d, need 0/0", stall, stage_a3);
        end
        flush();
        @(negedge clk);
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd4, 1'b1, 2'd3);
        @(negedge clk);
        driveD(1'b0, 5'd4, 5'd4, 2'd0, 2'd0, 5'd9, 1'b1, 2'd1);
        #1;
        testsRun++;
        if (stall !== 1'b0 || stage_a3 !== 15'd4) begin
            testsFailed++;
            $display("[TB] FAIL invalid_d: stall=%0b a3=%0d, need 0/4", stall, stage_a3);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (stage_a3 !== 15'd128) begin
            testsFailed++;
            $display("[TB] FAIL bubble_insert: a3=%0d, need 128", stage_a3);
        end
    endtask

`ifdef HAZARD_MD_EN
    task automatic test_md();
        flush();
        @(negedge clk);
        md_busy = 1'b1;
        d_md_op = 1'b1;
        driveD(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 1'b1, 2'd1);
        for (int c = 0; c < 5; c++) begin
            #1;
            testsRun++;
            if (stall !== 1'b1 || stage_a3[4:0] !== 5'd0) begin
                testsFailed++;
                $display("[TB] FAIL md_busy_stall%0d: stall=%0b s1=%0d, need 1/0",
                         c, stall, stage_a3[4:0]);
            end
            @(negedge clk);
        end
        md_busy = 1'b0;
        #1;
        testsRun++;
        if (stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL md_release: stall=%0b, need 0", stall);
        end
        @(negedge clk);
        #1;
        testsRun++;
        if (stage_a3[4:0] !== 5'd9) begin
            testsFailed++;
            $display("[TB] FAIL md_issue: s1=%0d, need 9", stage_a3[4:0]);
        end
        md_start = 1'b1;
        #1;
        testsRun++;
        if (stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL md_start: stall=%0b, need 1", stall);
        end
        md_start = 1'b0;
        d_md_op  = 1'b0;
    endtask
`endif

    initial begin
        testsRun    = 0;
        testsFailed = 0;
`ifdef HAZARD_MD_EN
        d_md_op  = 1'b0;
        md_busy  = 1'b0;
        md_start = 1'b0;
`endif
        test_reset();
        test_load_use();
        test_branch_load();
        test_alu_branch();
        test_fwd_priority();
        test_no_hazard();
`ifdef HAZARD_MD_EN
        test_md();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
